// File: rtl/addsub_pkg.sv
// Shared constants and types for the addsub adder/subtractor block.
package addsub_pkg;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

endpackage

// File: rtl/addsub_rca.sv
// Ripple-carry adder with carry-in; also exposes the carry into the MSB
// so the caller can derive signed overflow.
module addsub_rca #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/addsub.sv
// Registered two's-complement adder/subtractor with carry/borrow, signed
// overflow and zero flags; one cycle of latency.
module addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    input  logic             add_sub,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    logic [WIDTH-1:0] b_eff_p0;
    logic             cin_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             cout_p0;
    logic             c_msb_p0;
    flags_t           flags_p0;

    logic [WIDTH-1:0] result_p1;
    flags_t           flags_p1;

    // Subtraction is dataa + ~datab + 1, so the carry-in doubles as the op select.
    assign b_eff_p0 = (add_sub == OP_ADD) ? datab : ~datab;
    assign cin_p0   = (add_sub == OP_SUB);

    addsub_rca #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a     (dataa),
        .b     (b_eff_p0),
        .cin   (cin_p0),
        .sum   (sum_p0),
        .cout  (cout_p0),
        .c_msb (c_msb_p0)
    );

    always_comb begin
        flags_p0          = '0;
        flags_p0.carry    = (add_sub == OP_ADD) ? cout_p0 : ~cout_p0;
        flags_p0.overflow = c_msb_p0 ^ cout_p0;
        flags_p0.zero     = (sum_p0 == '0);
    end

    // Stage p0 -> p1: output registers; zero is forced low while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
            flags_p1  <= '0;
        end else begin
            result_p1 <= sum_p0;
            flags_p1  <= flags_p0;
        end
    end

    assign result   = result_p1;
    assign carry    = flags_p1.carry;
    assign overflow = flags_p1.overflow;
    assign zero     = flags_p1.zero;

endmodule

// File: tb/tb_addsub.sv
// Directed self-checking bench for addsub at WIDTH=8.
module tb_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic             add_sub;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    int checks = 0;
    int errors = 0;

    addsub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dataa    (dataa),
        .datab    (datab),
        .add_sub  (add_sub),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int r, input int c, input int o, input int z);
        check({tag, ".result"},   int'(result),   r);
        check({tag, ".carry"},    int'(carry),    c);
        check({tag, ".overflow"}, int'(overflow), o);
        check({tag, ".zero"},     int'(zero),     z);
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic op(input string tag, input int a, input int b, input logic add,
                      input int r, input int c, input int o, input int z);
        @(negedge clk);
        dataa   = WIDTH'(a);
        datab   = WIDTH'(b);
        add_sub = add;
        @(posedge clk);
        #1;
        check_all(tag, r, c, o, z);
    endtask

    initial begin
        rst_n   = 1'b1;
        dataa   = 8'd9;
        datab   = 8'd2;
        add_sub = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all("reset_noclk", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_clocked", 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("release_9m2", 7, 0, 0, 0);

        op("sub_9_2",     9,   2,   1'b0, 7,   0, 0, 0);
        op("add_3_2",     3,   2,   1'b1, 5,   0, 0, 0);
        op("sub_4_4",     4,   4,   1'b0, 0,   0, 0, 1);
        op("add_10_2",    10,  2,   1'b1, 12,  0, 0, 0);
        op("sub_10_2",    10,  2,   1'b0, 8,   0, 0, 0);
        op("sub_0_2",     0,   2,   1'b0, 254, 1, 0, 0);
        op("sub_9_10",    9,   10,  1'b0, 255, 1, 0, 0);
        op("add_0_2",     0,   2,   1'b1, 2,   0, 0, 0);
        op("add_200_100", 200, 100, 1'b1, 44,  1, 0, 0);
        op("add_100_100", 100, 100, 1'b1, 200, 0, 1, 0);
        op("sub_128_1",   128, 1,   1'b0, 127, 0, 1, 0);
        op("add_127_1",   127, 1,   1'b1, 128, 0, 1, 0);
        op("add_255_1",   255, 1,   1'b1, 0,   1, 0, 1);
        op("sub_0_0",     0,   0,   1'b0, 0,   0, 0, 1);

        // Mid-cycle input change must not reach the outputs before the next edge.
        op("hold_base", 10, 2, 1'b1, 12, 0, 0, 0);
        #2;
        dataa = 8'd50;
        #1;
        check("hold_midcycle.result", int'(result), 12);
        @(posedge clk);
        #1;
        check("hold_nextedge.result", int'(result), 52);

        // Flipping add_sub alone.
        op("flip_add", 10, 2, 1'b1, 12, 0, 0, 0);
        @(negedge clk);
        add_sub = 1'b0;
        @(posedge clk);
        #1;
        check("flip_sub.result", int'(result), 8);

        // Reset asserted just before the edge discards the pending operation.
        @(negedge clk);
        dataa   = 8'd3;
        datab   = 8'd2;
        add_sub = 1'b1;
        #4;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_midstream", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after_reset_add", 5, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
